// File: rtl/regfile_bypass.sv
// Single-bit storage cell with asynchronous active-low clear.
module dff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end
endmodule

// Register file: 1 registered write port, 2 combinational read ports, optional write-to-read bypass.
// Latency: reads 0 cycles, writes visible on the storage path after the next rising edge.
// Backpressure: none; a write is accepted on every edge where writeEn is high.
module regfile_bypass #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3,
  parameter bit BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read1RegSel,
  input  logic [ADDR_W-1:0] read2RegSel,
  input  logic [ADDR_W-1:0] writeRegSel,
  input  logic [WIDTH-1:0]  writeData,
  input  logic              writeEn,
  output logic [WIDTH-1:0]  read1Data,
  output logic [WIDTH-1:0]  read2Data,
  output logic              err
);

  logic [NREGS-1:0][WIDTH-1:0] regs;
  logic [NREGS-1:0][WIDTH-1:0] nxt;

  for (genvar r = 0; r < NREGS; r++) begin : g_reg
    assign nxt[r] = (writeEn && (writeRegSel == ADDR_W'(r))) ? writeData : regs[r];
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      dff u_dff (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (nxt[r][b]),
        .q     (regs[r][b])
      );
    end
  end

  logic fwd1, fwd2;

  always_comb begin
    fwd1 = BYPASS && rst_n && writeEn && (writeRegSel == read1RegSel);
    fwd2 = BYPASS && rst_n && writeEn && (writeRegSel == read2RegSel);
    // Storage is already clear in reset; the explicit gate keeps outputs 0 for X selects too.
    read1Data = '0;
    read2Data = '0;
    if (rst_n) begin
      read1Data = fwd1 ? writeData : regs[read1RegSel];
      read2Data = fwd2 ? writeData : regs[read2RegSel];
    end
  end

`ifdef SYNTHESIS
  assign err = 1'b0;
`else
  always_comb begin
    err = rst_n && $isunknown({writeEn, writeRegSel, read1RegSel, read2RegSel});
  end
`endif

endmodule

// File: tb/tb_regfile_bypass.sv
// Bench: table-driven vectors plus reset/err sequences, checked against BYPASS=1 and BYPASS=0 instances.
module tb_regfile_bypass;

  logic        clk = 1'b0;
  bit          clk_en = 1'b1;
  logic        rst_n;
  logic [2:0]  r1, r2, wsel;
  logic [15:0] wdata;
  logic        we;
  logic [15:0] a_byp, b_byp, a_nob, b_nob;
  logic        err_byp, err_nob;

  int total = 0;
  int bad   = 0;

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  regfile_bypass #(.WIDTH(16), .NREGS(8), .ADDR_W(3), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst_n(rst_n), .read1RegSel(r1), .read2RegSel(r2),
    .writeRegSel(wsel), .writeData(wdata), .writeEn(we),
    .read1Data(a_byp), .read2Data(b_byp), .err(err_byp)
  );

  regfile_bypass #(.WIDTH(16), .NREGS(8), .ADDR_W(3), .BYPASS(1'b0)) u_nob (
    .clk(clk), .rst_n(rst_n), .read1RegSel(r1), .read2RegSel(r2),
    .writeRegSel(wsel), .writeData(wdata), .writeEn(we),
    .read1Data(a_nob), .read2Data(b_nob), .err(err_nob)
  );

  typedef struct {
    string       name;
    bit          chk_data;
    logic [15:0] a1, b1, a0, b0;
    logic        e;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic [2:0]  r1, r2;
    logic [15:0] a1, b1, a0, b0;
  } vec_t;

  vec_t vt[14];

  task automatic cmp(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic pop_check();
    exp_t x;
    x = sb.pop_front();
    if (x.chk_data) begin
      cmp({x.name, ".a_byp"}, a_byp, x.a1);
      cmp({x.name, ".b_byp"}, b_byp, x.b1);
      cmp({x.name, ".a_nob"}, a_nob, x.a0);
      cmp({x.name, ".b_nob"}, b_nob, x.b0);
    end
    cmp({x.name, ".err_byp"}, 16'(err_byp), 16'(x.e));
    cmp({x.name, ".err_nob"}, 16'(err_nob), 16'(x.e));
  endtask

  task automatic expect_now(string nm, bit cd, logic [15:0] a1, logic [15:0] b1,
                            logic [15:0] a0, logic [15:0] b0, logic e);
    exp_t x;
    x.name = nm; x.chk_data = cd;
    x.a1 = a1; x.b1 = b1; x.a0 = a0; x.b0 = b0; x.e = e;
    sb.push_back(x);
    #1;
    pop_check();
  endtask

  initial begin
    // Rows start from an all-zero register file; each row is driven at negedge and
    // checked before the following rising edge commits it.
    //          we    wsel  wdata     r1    r2    a_byp     b_byp     a_nob     b_nob
    vt[0]  = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd5, 16'hA5A5, 16'h0000, 16'h0000, 16'h0000};
    vt[1]  = '{1'b1, 3'd5, 16'h5A5A, 3'd3, 3'd5, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h0000};
    vt[2]  = '{1'b0, 3'd3, 16'h1234, 3'd3, 3'd5, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};
    vt[3]  = '{1'b0, 3'd3, 16'h1234, 3'd3, 3'd5, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};
    vt[4]  = '{1'b0, 3'd3, 16'h1234, 3'd3, 3'd5, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};
    vt[5]  = '{1'b0, 3'd3, 16'h1234, 3'd3, 3'd5, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};
    vt[6]  = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'hA5A5, 16'h5A5A, 16'hA5A5, 16'h5A5A};
    vt[7]  = '{1'b1, 3'd2, 16'hBEEF, 3'd2, 3'd2, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
    vt[8]  = '{1'b1, 3'd2, 16'h1357, 3'd2, 3'd2, 16'h1357, 16'h1357, 16'hBEEF, 16'hBEEF};
    vt[9]  = '{1'b1, 3'd0, 16'h0F0F, 3'd0, 3'd2, 16'h0F0F, 16'h1357, 16'h0000, 16'h1357};
    vt[10] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 16'h0F0F, 16'h0F0F, 16'h0F0F, 16'h0F0F};
    vt[11] = '{1'b1, 3'd7, 16'hFFFF, 3'd7, 3'd3, 16'hFFFF, 16'hA5A5, 16'h0000, 16'hA5A5};
    vt[12] = '{1'b1, 3'd7, 16'h0001, 3'd5, 3'd7, 16'h5A5A, 16'h0001, 16'h5A5A, 16'hFFFF};
    vt[13] = '{1'b0, 3'd7, 16'h0000, 3'd7, 3'd6, 16'h0001, 16'h0000, 16'h0001, 16'h0000};

    rst_n = 1'b0; we = 1'b0; wsel = 3'd0; wdata = 16'h0; r1 = 3'd0; r2 = 3'd7;
    expect_now("por", 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    #1 rst_n = 1'b1;

    // Fill every register with all-ones, then reset with the clock stopped.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      we = 1'b1; wsel = 3'(i); wdata = 16'hFFFF;
    end
    @(negedge clk);
    we = 1'b0; r1 = 3'd0; r2 = 3'd7;
    expect_now("fill", 1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b0);
    clk_en = 1'b0;
    #2;
    rst_n = 1'b0; we = 1'b1; wsel = 3'd2; wdata = 16'h1111;
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i); r2 = 3'(7 - i);
      expect_now("rst_rd", 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    end
    we = 1'b0; #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      r1 = 3'(i); r2 = 3'(i);
      expect_now("rst_rel", 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    end
    clk_en = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      we = vt[i].we; wsel = vt[i].wsel; wdata = vt[i].wdata; r1 = vt[i].r1; r2 = vt[i].r2;
      expect_now($sformatf("vec%0d", i), 1'b1, vt[i].a1, vt[i].b1, vt[i].a0, vt[i].b0, 1'b0);
    end

    // Reset asserted while a write is pending across the rising edge.
    @(negedge clk);
    we = 1'b1; wsel = 3'd7; wdata = 16'hCAFE; r1 = 3'd7; r2 = 3'd3;
    #2 rst_n = 1'b0;
    expect_now("rmw_in", 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; we = 1'b0;
    expect_now("rmw_after", 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);

    // X/Z select detection; suppressed while in reset.
    @(negedge clk);
    begin
      logic [2:0] xsel;
      logic       xe;
      xsel = 3'bx1x;
      r2 = xsel;
      xe = $isunknown({we, wsel, r1, r2});
      expect_now("err_x", 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, xe);
      rst_n = 1'b0;
      expect_now("err_rst", 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
      rst_n = 1'b1;
      r2 = 3'b010;
      expect_now("err_clr", 1'b1, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
